vend_credit_controller: RTL and testbench
=========================================

// Module: vend_credit_controller
// PURPOSE
//  Sequencer in front of the vending product FSM/dispenser. Accumulates coin credit,
//  validates a product selection against price and sold-out status, drives the
//  dispense handshake, then pays change/refunds one 5-unit coin per handshake.
//  Sits between the coin acceptor/keypad front end and the dispenser/change hopper.
// PARAMETERS
//  PRICE0          5     price of product 0 (units)
//  PRICE1          10    price of product 1
//  PRICE2          15    price of product 2
//  PRICE3          20    price of product 3
//  MAX_CREDIT      95    credit ceiling (units); must be a multiple of 5 and <= 255
//  TIMEOUT_CYCLES  1000  idle cycles before auto-refund (used only with VEND_TIMEOUT_EN)
// PORTS
//  clk           in   1  clock, rising edge
//  reset         in   1  asynchronous, active-low reset
//  coin_valid    in   1  coin present this cycle (single-cycle pulse)
//  coin          in   3  000=none 001=5 010=10 011=20; 1xx invalid
//  select        in   1  selection strobe (single-cycle pulse)
//  choice        in   2  product index qualified by select
//  cancel        in   1  refund request (pulse)
//  sold_out      in   4  per-product empty flag from dispenser
//  dispense_req  out  1  request dispense of dispense_id
//  dispense_id   out  2  latched product index
//  dispense_ack  in   1  dispenser done
//  change_req    out  1  request one 5-unit coin from hopper
//  change_ack    in   1  one coin paid
//  credit        out  8  current credit (units)
//  busy          out  1  high in VEND or CHANGE
//  coin_reject   out  1  1-cycle pulse: coin not accepted
//  deny          out  1  1-cycle pulse: selection refused
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; credit=0; all outputs 0; credit in flight is lost.
//  States: IDLE(credit==0) / COLLECT / VEND / CHANGE. busy = (VEND|CHANGE).
//  IDLE/COLLECT, coin_valid:
//   - valid code and credit+value<=MAX_CREDIT -> credit+=value next cycle; IDLE->COLLECT.
//   - invalid code or overflow -> coin_reject pulse next cycle; credit unchanged.
//  COLLECT, select (evaluated on registered credit):
//   - sold_out[choice] or credit<PRICEn -> deny pulse next cycle; stay COLLECT.
//   - else credit-=PRICEn, dispense_id<=choice, ->VEND; dispense_req=1 from next cycle.
//   - select in IDLE -> deny pulse.
//  Priority in one cycle: cancel > select > coin; a coin that loses -> coin_reject.
//  COLLECT, cancel -> CHANGE (full refund). cancel in IDLE/VEND/CHANGE ignored.
//  VEND: dispense_req held high, dispense_id stable, until dispense_ack sampled 1;
//   next cycle dispense_req=0 and state -> CHANGE if credit>0, else IDLE.
//   Ack may arrive in the first VEND cycle (min 1-cycle req pulse).
//  CHANGE: change_req=1; each cycle with change_ack=1, credit-=5. When credit reaches 0,
//   change_req drops same edge and state->IDLE. change_ack outside CHANGE ignored.
//  Coins in VEND/CHANGE -> coin_reject. credit never underflows or exceeds MAX_CREDIT.
//  All outputs registered; latency coin->credit and select->dispense_req = 1 cycle.
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: idle counter in COLLECT, cleared by any coin_valid/select/
//   cancel; reaching TIMEOUT_CYCLES forces COLLECT->CHANGE (same as cancel).
//  Not defined: no counter; COLLECT waits indefinitely; TIMEOUT_CYCLES unused.
// TESTING
//  T1 reset low mid-VEND -> immediately dispense_req=0, credit=0, busy=0, state IDLE.
//  T2 coins 10,10, select choice=3 (20), ack after 3 cycles -> credit 20->0,
//     dispense_req 3 cycles, dispense_id=3, no change_req, back to IDLE.
//  T3 coins 20,5, select choice=1 (10) -> dispense, then change_req for 3 acks,
//     credit 15->10->5->0, IDLE.
//  T4 credit 10, select choice=2 -> deny pulse, credit 10; sold_out[0]=1, select 0 -> deny.
//  T5 credit 90, coin 10 -> coin_reject, credit 90; coin=3'b100 -> coin_reject;
//     same-cycle cancel+select at credit 10 -> CHANGE, 2 change_acks, no dispense_req.
//  T6 (VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8) coin 5 then idle 8 cycles -> change_req,
//     one ack -> IDLE; without macro credit stays 5 for 100 cycles.

Source files
------------

// File: rtl/vend_credit_controller_if.sv
// Front-end / dispenser / hopper signal bundle for vend_credit_controller.
// The controller connects through the slave modport; the driving side uses master.
interface vend_credit_controller_if;
  logic       coin_valid;
  logic [2:0] coin;
  logic       select;
  logic [1:0] choice;
  logic       cancel;
  logic [3:0] sold_out;
  logic       dispense_req;
  logic [1:0] dispense_id;
  logic       dispense_ack;
  logic       change_req;
  logic       change_ack;
  logic [7:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       deny;

  modport master (
    output coin_valid, coin, select, choice, cancel, sold_out, dispense_ack, change_ack,
    input  dispense_req, dispense_id, change_req, credit, busy, coin_reject, deny
  );

  modport slave (
    input  coin_valid, coin, select, choice, cancel, sold_out, dispense_ack, change_ack,
    output dispense_req, dispense_id, change_req, credit, busy, coin_reject, deny
  );
endinterface

// File: rtl/vend_credit_controller.sv
// Vending credit sequencer: coin accumulation, selection check, dispense and change handshakes.
// Optional idle auto-refund is enabled by defining VEND_TIMEOUT_EN.
module vend_credit_controller #(
  parameter int PRICE0         = 5,
  parameter int PRICE1         = 10,
  parameter int PRICE2         = 15,
  parameter int PRICE3         = 20,
  parameter int MAX_CREDIT     = 95,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                      clk,
  input logic                      reset,
  vend_credit_controller_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  localparam logic [7:0] MAX_CREDIT_C = 8'(MAX_CREDIT);
  localparam logic [7:0] COIN_UNIT    = 8'd5;

  if (((MAX_CREDIT % 5) != 0) || (MAX_CREDIT > 255) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_check
    $error("vend_credit_controller: invalid MAX_CREDIT or TIMEOUT_CYCLES");
  end

  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (code)
      3'b001:  coin_value = 8'd5;
      3'b010:  coin_value = 8'd10;
      3'b011:  coin_value = 8'd20;
      default: coin_value = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 8'(PRICE0);
      2'd1:    price_of = 8'(PRICE1);
      2'd2:    price_of = 8'(PRICE2);
      default: price_of = 8'(PRICE3);
    endcase
  endfunction

  logic [1:0] state_r;
  logic [7:0] credit_r;
  logic       dispense_req_r;
  logic [1:0] dispense_id_r;
  logic       change_req_r;
  logic       busy_r;
  logic       coin_reject_r;
  logic       deny_r;

  logic [1:0] state_s;
  logic [7:0] credit_s;
  logic       dispense_req_s;
  logic [1:0] dispense_id_s;
  logic       change_req_s;
  logic       busy_s;
  logic       coin_reject_s;
  logic       deny_s;
  logic       timeout_s;

  logic [7:0] coin_val_s;
  logic [8:0] coin_sum_s;
  logic       coin_fits_s;
  logic [7:0] price_s;
  logic       can_buy_s;

  assign coin_val_s  = coin_value(bus.coin);
  assign coin_sum_s  = {1'b0, credit_r} + {1'b0, coin_val_s};
  assign coin_fits_s = (coin_val_s != 8'd0) && (coin_sum_s <= {1'b0, MAX_CREDIT_C});
  assign price_s     = price_of(bus.choice);
  assign can_buy_s   = !bus.sold_out[bus.choice] && (credit_r >= price_s);

`ifdef VEND_TIMEOUT_EN
  logic [31:0] idle_cnt_r;
  logic        activity_s;

  assign activity_s = bus.coin_valid | bus.select | bus.cancel;
  assign timeout_s  = (state_r == S_COLLECT) && !activity_s &&
                      (idle_cnt_r == 32'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while COLLECT sees no user activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_r <= 32'd0;
    end else if ((state_r != S_COLLECT) || activity_s || timeout_s) begin
      idle_cnt_r <= 32'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic; priority in IDLE/COLLECT is cancel, then select, then coin.
  always_comb begin
    state_s        = state_r;
    credit_s       = credit_r;
    dispense_req_s = dispense_req_r;
    dispense_id_s  = dispense_id_r;
    change_req_s   = change_req_r;
    coin_reject_s  = 1'b0;
    deny_s         = 1'b0;
    case (state_r)
      S_IDLE, S_COLLECT: begin
        if ((state_r == S_COLLECT) && (bus.cancel || timeout_s)) begin
          state_s       = S_CHANGE;
          change_req_s  = 1'b1;
          coin_reject_s = bus.coin_valid;
        end else if (bus.select) begin
          coin_reject_s = bus.coin_valid;
          if ((state_r == S_COLLECT) && can_buy_s) begin
            credit_s       = credit_r - price_s;
            dispense_id_s  = bus.choice;
            dispense_req_s = 1'b1;
            state_s        = S_VEND;
          end else begin
            deny_s = 1'b1;
          end
        end else if (bus.coin_valid) begin
          if (coin_fits_s) begin
            credit_s = coin_sum_s[7:0];
            state_s  = S_COLLECT;
          end else begin
            coin_reject_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_VEND: begin
        coin_reject_s = bus.coin_valid;
        if (bus.dispense_ack) begin
          dispense_req_s = 1'b0;
          if (credit_r != 8'd0) begin
            state_s      = S_CHANGE;
            change_req_s = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_VEND;
        end
      end
      S_CHANGE: begin
        coin_reject_s = bus.coin_valid;
        if (bus.change_ack) begin
          // Last coin drops the request on the same edge credit hits zero.
          if (credit_r <= COIN_UNIT) begin
            credit_s     = 8'd0;
            change_req_s = 1'b0;
            state_s      = S_IDLE;
          end else begin
            credit_s = credit_r - COIN_UNIT;
          end
        end else begin
          state_s = S_CHANGE;
        end
      end
      default: begin
        state_s        = S_IDLE;
        credit_s       = 8'd0;
        dispense_req_s = 1'b0;
        change_req_s   = 1'b0;
      end
    endcase
    busy_s = (state_s == S_VEND) || (state_s == S_CHANGE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= S_IDLE;
      credit_r       <= 8'd0;
      dispense_req_r <= 1'b0;
      dispense_id_r  <= 2'd0;
      change_req_r   <= 1'b0;
      busy_r         <= 1'b0;
      coin_reject_r  <= 1'b0;
      deny_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      credit_r       <= credit_s;
      dispense_req_r <= dispense_req_s;
      dispense_id_r  <= dispense_id_s;
      change_req_r   <= change_req_s;
      busy_r         <= busy_s;
      coin_reject_r  <= coin_reject_s;
      deny_r         <= deny_s;
    end
  end

  assign bus.credit       = credit_r;
  assign bus.dispense_req = dispense_req_r;
  assign bus.dispense_id  = dispense_id_r;
  assign bus.change_req   = change_req_r;
  assign bus.busy         = busy_r;
  assign bus.coin_reject  = coin_reject_r;
  assign bus.deny         = deny_r;

endmodule

// File: tb/tb_vend_credit_controller.sv
// Directed scoreboard bench for vend_credit_controller; expected output vectors are queued
// with each stimulus step and compared one cycle later. Honours VEND_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_vend_credit_controller;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  vend_credit_controller_if vif();

  vend_credit_controller #(
    .PRICE0(5), .PRICE1(10), .PRICE2(15), .PRICE3(20),
    .MAX_CREDIT(95), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  // {credit, dispense_req, dispense_id, change_req, busy, coin_reject, deny}
  typedef logic [14:0] exp_t;
  exp_t  sb_q[$];
  string tag_q[$];
  logic [14:0] obs_s;

  assign obs_s = {vif.credit, vif.dispense_req, vif.dispense_id, vif.change_req,
                  vif.busy, vif.coin_reject, vif.deny};

  task automatic push(input string tag, input logic [7:0] c, input logic dr,
                      input logic [1:0] di, input logic cr, input logic b,
                      input logic rj, input logic dn);
    sb_q.push_back({c, dr, di, cr, b, rj, dn});
    tag_q.push_back(tag);
  endtask

  task automatic check_front();
    exp_t  e;
    string t;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs_s);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      assert (obs_s === e) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", t, obs_s, e);
      end
    end
  endtask

  task automatic clear_pulses();
    vif.coin_valid   = 1'b0;
    vif.coin         = 3'b000;
    vif.select       = 1'b0;
    vif.cancel       = 1'b0;
    vif.dispense_ack = 1'b0;
    vif.change_ack   = 1'b0;
  endtask

  task automatic step(input string tag, input logic [7:0] c, input logic dr,
                      input logic [1:0] di, input logic cr, input logic b,
                      input logic rj, input logic dn);
    push(tag, c, dr, di, cr, b, rj, dn);
    @(posedge clk);
    #1;
    check_front();
    clear_pulses();
  endtask

  task automatic coin_in(input logic [2:0] code);
    vif.coin_valid = 1'b1;
    vif.coin       = code;
  endtask

  task automatic sel(input logic [1:0] ch);
    vif.select = 1'b1;
    vif.choice = ch;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    vif.choice   = 2'd0;
    vif.sold_out = 4'b0000;
    clear_pulses();
    repeat (2) @(posedge clk);
    #1;
    push("reset_state", 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_front();
    reset = 1'b1;
    step("idle_after_reset", 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T2: exact payment, ack after three request cycles, no change.
    coin_in(3'b010); step("t2_coin10a", 8'd10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    coin_in(3'b010); step("t2_coin10b", 8'd20, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sel(2'd3);       step("t2_select3", 8'd0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t2_req_hold1", 8'd0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t2_req_hold2", 8'd0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    vif.dispense_ack = 1'b1;
    step("t2_ack_idle", 8'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t2_stay_idle", 8'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    sel(2'd0);       step("idle_select_deny", 8'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    vif.cancel = 1'b1;
    step("idle_cancel_ignored", 8'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // T3: overpay, ack in first VEND cycle, three change coins.
    coin_in(3'b011); step("t3_coin20", 8'd20, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    coin_in(3'b001); step("t3_coin5", 8'd25, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    sel(2'd1);       step("t3_select1", 8'd15, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    vif.dispense_ack = 1'b1;
    step("t3_ack_first_cycle", 8'd15, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    coin_in(3'b001); step("t3_coin_in_change", 8'd15, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    vif.change_ack = 1'b1; step("t3_change1", 8'd10, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    vif.change_ack = 1'b1; step("t3_change2", 8'd5, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    vif.change_ack = 1'b1; step("t3_change3", 8'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    vif.change_ack = 1'b1; step("stray_change_ack", 8'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // T4: insufficient credit and sold-out denial.
    coin_in(3'b010); step("t4_coin10", 8'd10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    sel(2'd2);       step("t4_deny_price", 8'd10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    vif.sold_out = 4'b0001;
    sel(2'd0);       step("t4_deny_sold_out", 8'd10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    vif.sold_out = 4'b0000;

    // T5: cancel beats select in the same cycle.
    vif.cancel = 1'b1;
    sel(2'd0);       step("t5_cancel_wins", 8'd10, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    vif.change_ack = 1'b1; step("t5_refund1", 8'd5, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    vif.change_ack = 1'b1; step("t5_refund2", 8'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // T5: credit ceiling and invalid coin codes.
    for (int k = 1; k <= 4; k++) begin
      coin_in(3'b011);
      step($sformatf("t5_fill%0d", k), 8'(20 * k), 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    coin_in(3'b010); step("t5_coin10_to90", 8'd90, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    coin_in(3'b010); step("t5_overflow_rej", 8'd90, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    coin_in(3'b001); step("t5_exact_max", 8'd95, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    coin_in(3'b001); step("t5_at_max_rej", 8'd95, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    coin_in(3'b100); step("t5_invalid_code", 8'd95, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    coin_in(3'b001);
    sel(2'd3);       step("select_beats_coin", 8'd75, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    vif.dispense_ack = 1'b1;
    step("vend_to_change", 8'd75, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      vif.change_ack = 1'b1;
      step($sformatf("drain%0d", k), 8'(75 - 5 * k), 1'b0, 2'd3,
           (k < 15), (k < 15), 1'b0, 1'b0);
    end

    // T1: asynchronous reset while dispensing.
    coin_in(3'b010); step("t1_coin10", 8'd10, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    sel(2'd1);       step("t1_select1", 8'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    push("t1_async_reset", 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_front();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("t1_after_reset", 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T6: idle behaviour with and without the auto-refund timer.
    coin_in(3'b001); step("t6_coin5", 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef VEND_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      step($sformatf("t6_idle%0d", k), 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step("t6_timeout_change", 8'd5, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    for (int k = 1; k <= 100; k++) begin
      step($sformatf("t6_wait%0d", k), 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    vif.cancel = 1'b1;
    step("t6_cancel", 8'd5, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    vif.change_ack = 1'b1;
    step("t6_refund_idle", 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
